// File: rtl/pool_kxk_stream_pkg.sv
// Shared constants and width helpers for the K x K pooling stage.
package pool_pkg;

   localparam int MODE_MAX = 0;
   localparam int MODE_AVG = 1;

   function automatic int log2i(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Averaging keeps 2*log2(K) guard bits so the K*K sum can never overflow.
   function automatic int acc_w(input int dw, input int k, input int mode);
      return (mode == MODE_AVG) ? dw + 2 * log2i(k) : dw;
   endfunction

endpackage

// File: rtl/pool_kxk_stream_combine.sv
// Per-channel pairwise combine: signed maximum or signed sum.
module pool_combine
   import pool_pkg::*;
#(
   parameter int W    = 32,
   parameter int MODE = MODE_MAX
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] y_o
);

   generate
      if (MODE == MODE_AVG) begin : g_sum
         assign y_o = a_i + b_i;
      end else begin : g_max
         assign y_o = (a_i > b_i) ? a_i : b_i;
      end
   endgenerate

endmodule

// File: rtl/pool_kxk_stream.sv
// Streaming K x K, stride-K max/average pooling with valid/ready handshake,
// frame-start resynchronisation and an end-of-frame marker.
module pool_kxk_stream
   import pool_pkg::*;
#(
   parameter int CH   = 16,
   parameter int DW   = 32,
   parameter int IN_W = 8,
   parameter int IN_H = 8,
   parameter int K    = 2,
   parameter int MODE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sof,
   input  logic [CH*DW-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic [CH*DW-1:0]   out_data,
   output logic               err_resync
);

   localparam int AW = acc_w(DW, K, MODE);
   localparam int LK = log2i(K);
   localparam int NB = IN_W / K;
   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;

   generate
      if ((IN_W % K) != 0 || (IN_H % K) != 0) begin : g_bad_dims
         $error("pool_kxk_stream: IN_W and IN_H must be multiples of K");
      end
      if (K < 2 || K > 8 || (K & (K - 1)) != 0) begin : g_bad_k
         $error("pool_kxk_stream: K must be a power of two in 2..8");
      end
   endgenerate

   logic [CW-1:0]        col_q, col_d, colEff;
   logic [RW-1:0]        row_q, row_d, rowEff;
   logic [BW-1:0]        bucket;
   logic                 accept, resync, colFirst, colLast, rowFirst, rowLast;
   logic                 vStore, outLoad, frameEnd;
   logic signed [AW-1:0] hAcc_q   [CH];
   logic signed [AW-1:0] hAcc_d   [CH];
   logic signed [AW-1:0] vbuf_q   [NB][CH];
   logic signed [AW-1:0] vEntry_d [CH];
   logic signed [AW-1:0] sExt     [CH];
   logic signed [AW-1:0] hComb    [CH];
   logic signed [AW-1:0] vComb    [CH];
   logic [CH*DW-1:0]     winRes;
   logic                 outValid_q, outLast_q, errResync_q;
   logic [CH*DW-1:0]     outData_q;

   assign in_ready = !outValid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign resync   = accept && in_sof && (col_q != '0 || row_q != '0);

   // An accepted start-of-frame always acts as pixel (0,0); stale partial
   // windows vanish because the first column and row of a window load.
   always_comb begin
      colEff = in_sof ? '0 : col_q;
      rowEff = in_sof ? '0 : row_q;
      col_d  = col_q;
      row_d  = row_q;
      if (accept) begin
         if (colEff == CW'(IN_W - 1)) begin
            col_d = '0;
            row_d = (rowEff == RW'(IN_H - 1)) ? '0 : rowEff + RW'(1);
         end else begin
            col_d = colEff + CW'(1);
            row_d = rowEff;
         end
      end
   end

   assign colFirst = (colEff[LK-1:0] == '0);
   assign colLast  = (colEff[LK-1:0] == LK'(K - 1));
   assign rowFirst = (rowEff[LK-1:0] == '0);
   assign rowLast  = (rowEff[LK-1:0] == LK'(K - 1));
   assign bucket   = BW'(colEff >> LK);
   assign vStore   = accept && colLast;
   assign outLoad  = vStore && rowLast;
   assign frameEnd = (colEff == CW'(IN_W - 1)) && (rowEff == RW'(IN_H - 1));

   for (genvar c = 0; c < CH; c++) begin : g_ch
      assign sExt[c] = AW'($signed(in_data[c*DW +: DW]));

      pool_combine #(.W(AW), .MODE(MODE)) u_hComb (
         .a_i (hAcc_q[c]),
         .b_i (sExt[c]),
         .y_o (hComb[c])
      );

      assign hAcc_d[c] = colFirst ? sExt[c] : hComb[c];

      pool_combine #(.W(AW), .MODE(MODE)) u_vComb (
         .a_i (vbuf_q[bucket][c]),
         .b_i (hAcc_d[c]),
         .y_o (vComb[c])
      );

      assign vEntry_d[c] = rowFirst ? hAcc_d[c] : vComb[c];

      if (MODE == MODE_AVG) begin : g_avg
         assign winRes[c*DW +: DW] = DW'(vEntry_d[c] >>> (2 * LK));
      end else begin : g_max
         assign winRes[c*DW +: DW] = vEntry_d[c][DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         outValid_q  <= 1'b0;
         outLast_q   <= 1'b0;
         outData_q   <= '0;
         errResync_q <= 1'b0;
         for (int c = 0; c < CH; c++) hAcc_q[c] <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         errResync_q <= resync;
         if (accept) begin
            for (int c = 0; c < CH; c++) hAcc_q[c] <= hAcc_d[c];
         end
         // A fresh result may replace the one draining this cycle.
         if (outLoad) begin
            outValid_q <= 1'b1;
            outLast_q  <= frameEnd;
            outData_q  <= winRes;
         end else if (out_ready) begin
            outValid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (vStore) begin
         for (int c = 0; c < CH; c++) vbuf_q[bucket][c] <= vEntry_d[c];
      end
   end

   assign out_valid  = outValid_q;
   assign out_last   = outLast_q;
   assign out_data   = outData_q;
   assign err_resync = errResync_q;

endmodule

// File: tb/tb_pool_kxk_stream.sv
// Directed bench for pool_kxk_stream: 2x2 max (main), 2x2 average and 4x4 max.
module tb_pool_kxk_stream;

   localparam int RDY_HIGH = 0;
   localparam int RDY_LOW  = 1;
   localparam int RDY_RAND = 2;

   typedef struct packed {
      logic         last;
      logic [511:0] data;
   } outBeat_t;

   logic clk = 1'b0;
   logic rst_n;

   logic         aInValid, aInReady, aInSof, aOutValid, aOutReady, aOutLast, aErr;
   logic [511:0] aInData, aOutData;
   logic         bInValid, bInReady, bInSof, bOutValid, bOutReady, bOutLast, bErr;
   logic [63:0]  bInData, bOutData;
   logic         cInValid, cInReady, cInSof, cOutValid, cOutReady, cOutLast, cErr;
   logic [63:0]  cInData, cOutData;

   int testCount  = 0;
   int failCount  = 0;
   int stallCount = 0;
   int errCount   = 0;
   int readyMode  = RDY_LOW;

   logic [511:0] pix [64];
   logic [63:0]  bVals [8];
   outBeat_t     aGot[$], aExp[$], bGot[$], cGot[$];

   always #5 clk = ~clk;

   pool_kxk_stream #(.CH(16), .DW(32), .IN_W(8), .IN_H(8), .K(2), .MODE(0)) u_dutA (
      .clk(clk), .rst_n(rst_n), .in_valid(aInValid), .in_ready(aInReady), .in_sof(aInSof),
      .in_data(aInData), .out_valid(aOutValid), .out_ready(aOutReady), .out_last(aOutLast),
      .out_data(aOutData), .err_resync(aErr));

   pool_kxk_stream #(.CH(2), .DW(32), .IN_W(4), .IN_H(2), .K(2), .MODE(1)) u_dutB (
      .clk(clk), .rst_n(rst_n), .in_valid(bInValid), .in_ready(bInReady), .in_sof(bInSof),
      .in_data(bInData), .out_valid(bOutValid), .out_ready(bOutReady), .out_last(bOutLast),
      .out_data(bOutData), .err_resync(bErr));

   pool_kxk_stream #(.CH(2), .DW(32), .IN_W(8), .IN_H(8), .K(4), .MODE(0)) u_dutC (
      .clk(clk), .rst_n(rst_n), .in_valid(cInValid), .in_ready(cInReady), .in_sof(cInSof),
      .in_data(cInData), .out_valid(cOutValid), .out_ready(cOutReady), .out_last(cOutLast),
      .out_data(cOutData), .err_resync(cErr));

   // Output transfers are recorded half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (aOutValid && aOutReady) aGot.push_back({aOutLast, aOutData});
      if (bOutValid && bOutReady) bGot.push_back({bOutLast, 512'(bOutData)});
      if (cOutValid && cOutReady) cGot.push_back({cOutLast, 512'(cOutData)});
      if (aErr) errCount++;
   end

   initial begin
      aOutReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            RDY_HIGH: aOutReady = 1'b1;
            RDY_LOW:  aOutReady = 1'b0;
            default:  aOutReady = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input bit sof, input bit gaps);
      int n;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
      end
      aInValid = 1'b1;
      aInData  = pix[idx];
      aInSof   = sof;
      n = 0;
      @(negedge clk);
      while (!aInReady && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n > 0) stallCount++;
      if (!aInReady) begin
         testCount++;
         failCount++;
         $error("[TB] FAIL acceptTimeout beat=%0d in_ready=0 required=1", idx);
      end
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      aInSof   = 1'b0;
   endtask

   function automatic logic [511:0] winMax(input int nch, input int k, input int wr, input int wc);
      logic [511:0]      r;
      logic signed [31:0] m, v;
      r = '0;
      for (int ch = 0; ch < nch; ch++) begin
         m = pix[wr*k*8 + wc*k][ch*32 +: 32];
         for (int dr = 0; dr < k; dr++) begin
            for (int dc = 0; dc < k; dc++) begin
               v = pix[(wr*k + dr)*8 + wc*k + dc][ch*32 +: 32];
               if (v > m) m = v;
            end
         end
         r[ch*32 +: 32] = m;
      end
      return r;
   endfunction

   task automatic pushExpA(input int nRowPairs);
      for (int wr = 0; wr < nRowPairs; wr++) begin
         for (int wc = 0; wc < 4; wc++) begin
            aExp.push_back({(wr == 3 && wc == 3), winMax(16, 2, wr, wc)});
         end
      end
   endtask

   task automatic rampFrame();
      for (int i = 0; i < 64; i++) pix[i] = {16{32'(i)}};
   endtask

   task automatic randomFrame();
      for (int i = 0; i < 64; i++) begin
         for (int ch = 0; ch < 16; ch++) begin
            pix[i][ch*32 +: 32] = ($urandom_range(0, 15) == 0) ? 32'h80000000 : $urandom;
         end
      end
   endtask

   task automatic sendFrameA(input bit gaps, input bit withSof);
      for (int i = 0; i < 64; i++) applyStimulus(i, withSof && (i == 0), gaps);
   endtask

   task automatic checkFrameA(input string tag);
      outBeat_t g, e;
      int       n;
      n = 0;
      while (aGot.size() < aExp.size() && n < 3000) begin
         n++;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      checkOutput({tag, "Count"}, 512'(aGot.size()), 512'(aExp.size()));
      while (aExp.size() > 0 && aGot.size() > 0) begin
         e = aExp.pop_front();
         g = aGot.pop_front();
         checkOutput({tag, "Data"}, g.data, e.data);
         checkOutput({tag, "Last"}, 512'(g.last), 512'(e.last));
      end
      aExp.delete();
      aGot.delete();
   endtask

   initial begin
      int errBase, stallBase;
      rst_n    = 1'b0;
      aInValid = 1'b0; aInSof = 1'b0; aInData = '0;
      bInValid = 1'b0; bInSof = 1'b0; bInData = '0; bOutReady = 1'b1;
      cInValid = 1'b0; cInSof = 1'b0; cInData = '0; cOutReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state with out_ready still low.
      @(negedge clk);
      checkOutput("rstValid", 512'(aOutValid), 512'(0));
      checkOutput("rstLast", 512'(aOutLast), 512'(0));
      checkOutput("rstData", aOutData, 512'(0));
      checkOutput("rstErr", 512'(aErr), 512'(0));
      checkOutput("rstInReady", 512'(aInReady), 512'(1));
      checkOutput("rstDataB", 512'(bOutData), 512'(0));
      @(posedge clk);
      #1;

      // Average mode: floor of negative sums, saturated extremes without overflow.
      bVals = '{ {32'd1, 32'hFFFFFFFF}, {32'd2, 32'hFFFFFFFE}, {32'h80000000, 32'h7FFFFFFF},
                 {32'h80000000, 32'h7FFFFFFF}, {32'd3, 32'hFFFFFFFD}, {32'd5, 32'hFFFFFFFC},
                 {32'h80000000, 32'h7FFFFFFF}, {32'h80000000, 32'h7FFFFFFF} };
      for (int i = 0; i < 8; i++) begin
         bInValid = 1'b1;
         bInData  = bVals[i];
         bInSof   = (i == 0);
         @(posedge clk);
         #1;
      end
      bInValid = 1'b0;
      bInSof   = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("avgCount", 512'(bGot.size()), 512'(2));
      if (bGot.size() == 2) begin
         checkOutput("avgNeg", bGot[0].data, 512'({32'd2, 32'hFFFFFFFD}));
         checkOutput("avgNegLast", 512'(bGot[0].last), 512'(0));
         checkOutput("avgExtreme", bGot[1].data, 512'({32'h80000000, 32'h7FFFFFFF}));
         checkOutput("avgExtremeLast", 512'(bGot[1].last), 512'(1));
      end
      @(posedge clk);
      #1;

      // 4x4 max against the bench model; one window is all most-negative values.
      for (int i = 0; i < 64; i++) begin
         pix[i] = '0;
         pix[i][31:0]  = $urandom;
         pix[i][63:32] = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      end
      for (int dr = 0; dr < 4; dr++) begin
         for (int dc = 0; dc < 4; dc++) pix[dr*8 + dc][31:0] = 32'h80000000;
      end
      for (int i = 0; i < 64; i++) begin
         cInValid = 1'b1;
         cInData  = pix[i][63:0];
         cInSof   = (i == 0);
         @(posedge clk);
         #1;
      end
      cInValid = 1'b0;
      cInSof   = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("k4Count", 512'(cGot.size()), 512'(4));
      if (cGot.size() == 4) begin
         for (int w = 0; w < 4; w++) begin
            checkOutput("k4Data", cGot[w].data, winMax(2, 4, w / 2, w % 2));
            checkOutput("k4Last", 512'(cGot[w].last), 512'(w == 3));
         end
      end
      @(posedge clk);
      #1;

      // Ramp frame with a ten-cycle downstream stall on the first result.
      rampFrame();
      pushExpA(4);
      for (int i = 0; i < 9; i++) applyStimulus(i, (i == 0), 1'b0);
      @(negedge clk);
      checkOutput("preValid", 512'(aOutValid), 512'(0));
      @(posedge clk);
      #1;
      applyStimulus(9, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("latValid", 512'(aOutValid), 512'(1));
      aInValid = 1'b1;
      aInData  = pix[10];
      repeat (10) begin
         checkOutput("stallReady", 512'(aInReady), 512'(0));
         checkOutput("stallData", aOutData, {16{32'd9}});
         @(negedge clk);
      end
      readyMode = RDY_HIGH;
      aInValid  = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(10, 1'b0, 1'b0);
      stallBase = stallCount;
      for (int i = 11; i < 64; i++) applyStimulus(i, 1'b0, 1'b0);
      checkOutput("noBubble", 512'(stallCount - stallBase), 512'(0));
      checkFrameA("ramp");

      // Unexpected start-of-frame at (3,2).
      @(posedge clk);
      #1;
      rampFrame();
      pushExpA(1);
      errBase = errCount;
      for (int i = 0; i < 19; i++) applyStimulus(i, (i == 0), 1'b0);
      randomFrame();
      pushExpA(4);
      sendFrameA(1'b0, 1'b1);
      checkFrameA("resync");
      checkOutput("errPulses", 512'(errCount - errBase), 512'(1));

      // Random input gaps and downstream backpressure.
      readyMode = RDY_RAND;
      for (int f = 0; f < 20; f++) begin
         @(posedge clk);
         #1;
         randomFrame();
         pushExpA(4);
         sendFrameA(1'b1, 1'b1);
         checkFrameA("rand");
      end

      // Reset mid-frame; the following frame arrives without a start marker.
      @(posedge clk);
      #1;
      randomFrame();
      for (int i = 0; i < 7; i++) applyStimulus(i, (i == 0), 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abortValid", 512'(aOutValid), 512'(0));
      checkOutput("abortGot", 512'(aGot.size()), 512'(0));
      @(posedge clk);
      #1;
      randomFrame();
      pushExpA(4);
      sendFrameA(1'b1, 1'b0);
      checkFrameA("postRst");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pool_kxk_stream.md
# pool_kxk_stream

Parametrised K×K, stride-K pooling stage for the CNN feature-map pipeline, replacing the fixed 2×2/16-channel max pool. It takes one pixel per accepted beat, with all CH channels packed on one bus, in raster order. It emits one pooled pixel per K×K window, in either max or average mode. Unlike its predecessor it has:
- full valid/ready backpressure,
- frame-start resynchronisation,
- an end-of-frame marker.

It sits between a conv/ReLU stage and the next conv or FC stage.

## Interface
Parameters:
- CH, 16, channel count; channel c occupies bits [c*DW +: DW].
- DW, 32, signed two's-complement sample width.
- IN_W, 8, input columns; must be a multiple of K (elaboration-time check).
- IN_H, 8, input rows; must be a multiple of K (elaboration-time check).
- K, 2, window size and stride; must be a power of two, 2..8.
- MODE, 0, 0 = max, 1 = average.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, stage can accept a beat.
- in_sof, in, 1, first pixel of a frame; qualified by in_valid.
- in_data, in, CH*DW, packed channel samples.
- out_valid, out, 1, pooled pixel valid.
- out_ready, in, 1, downstream accepts.
- out_last, out, 1, last pooled pixel of the frame; qualified by out_valid.
- out_data, out, CH*DW, packed pooled samples.
- err_resync, out, 1, one-cycle pulse on unexpected in_sof.

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- Counters col (0..IN_W-1) and row (0..IN_H-1) advance only on an accepted beat.
- Wrap: col to 0 at IN_W-1. row increments on col wrap and wraps to 0 at IN_H-1.
- Per channel, the horizontal accumulator h_acc operates as follows:
  - When col%K==0, h_acc loads the sample.
  - Otherwise h_acc combines the sample (max, or sum).
- Column buffer vbuf[IN_W/K] per channel; the entry used is vbuf[col/K]. It is updated at the accepted beat with col%K==K-1:
  - If row%K==0, the entry loads the horizontal result.
  - Otherwise the entry combines the horizontal result.
  - No buffer reset is needed because the first row of every window loads.
- Accumulator width:
  - MODE 0: DW.
  - MODE 1: DW + 2*log2(K), signed.
- Output: on an accepted beat with col%K==K-1 and row%K==K-1, register the window result into out_data and set out_valid.
  - MODE 0 result: the maximum of the K² samples.
  - MODE 1 result: arithmetic right shift of the sum by 2*log2(K), i.e. floor toward −∞, truncated to DW. This cannot overflow.
- out_last=1 when that beat is (col,row)=(IN_W-1,IN_H-1).
- out_valid clears on out_valid && out_ready unless a new result loads the same cycle. Simultaneous drain and load is allowed and is full throughput.
- in_sof accepted while (col,row)==(0,0): normal operation.
- in_sof accepted while (col,row)≠(0,0):
  - The beat is treated as pixel (0,0); the counters then move to (1,0).
  - err_resync pulses for one cycle.
  - Partial windows are discarded.
  - A pending out_valid beat is kept and still delivered.
- in_sof is ignored when the beat is not accepted.

## Timing
- Latency: out_valid rises the cycle after the accepted beat that completes a window.
- Throughput: 1 input beat per cycle while out_ready=1.
- Input-to-output rate: one output per K² inputs.
- Reset values: out_valid=0, out_last=0, out_data=0, err_resync=0, col=0, row=0, h_acc=0. in_ready=1 after reset (combinational).
- Asynchronous reset mid-frame abandons the frame. The next accepted beat is (0,0) whether or not in_sof is set.
- out_data/out_last hold stable while out_valid && !out_ready.

## Structure
- Package pool_pkg contains:
  - MODE_MAX=0 and MODE_AVG=1.
  - A log2 helper function.
  - The accumulator-width function acc_w(DW,K,MODE).
- Sub-module pool_combine: per-channel combinational combine. Max, or signed add, selected by MODE, with width acc_w. It is instantiated CH times each for the horizontal and vertical paths.
- The top level holds the counters, h_acc, vbuf, the output register and the handshake.

## Test plan
- CH=16, DW=32, K=2, MODE=0, 8×8 ramp (pixel value = row*8+col, same in all channels) -> 16 outputs, value = (2r+1)*8+2c+1; out_last only on the 16th.
- MODE=1, K=2, window {−1,−2,−3,−4} -> out = −3 (floor of −10/4 = −2.5); window {0x7FFFFFFF ×4} -> 0x7FFFFFFF with no overflow.
- K=4, 8×8, MODE=0, random signed data incl. 0x80000000 -> matches a golden model; exactly 4 outputs.
- out_ready held 0 for 10 cycles once the first output is pending -> in_ready=0, out_data stable, no beat lost. After release, full-rate streaming with no bubbles.
- in_sof asserted at (col,row)=(3,2) -> err_resync pulses once, and the following 64 beats produce a correct frame with 16 outputs.
- Random in_valid/out_ready gaps (50%) over 20 frames, plus an rst_n pulse mid-frame -> scoreboard match and no output from the abandoned frame.
